cache_arbiter: RTL and testbench

Two-requester arbiter sharing the single physical-memory port between the instruction cache and the data cache of the RV32I core. It sits below both caches and above the main memory model. It serialises their line transactions through a three-state FSM and routes the memory handshake (read/write strobes, address, line data, response) to exactly one requester at a time. The CPU control FSM and caches are unchanged; each cache sees an apparently private memory port.

---
 rtl/cache_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single physical-memory port between the instruction cache and
// the data cache. Line transactions are serialised through a three-state FSM
// (IDLE, I_BUSY, D_BUSY) and the memory handshake is routed to exactly one
// requester at a time, so each cache sees an apparently private memory port.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate via a 1-bit last-grant
//               register (reset value "last granted D", so I wins first tie)
//   undefined : fixed priority, the data cache wins every tie
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_read, i_addr                instruction-cache line read request
//   i_rdata, i_resp               line / completion back to instruction cache
//   d_read, d_write, d_addr,      data-cache line read / writeback request
//   d_wdata
//   d_rdata, d_resp               line / completion back to data cache
//   pmem_read, pmem_write,        memory-side strobes, address and write line
//   pmem_addr, pmem_wdata
//   pmem_rdata, pmem_resp         memory-side read line and completion
// ---------------------------------------------------------------------------
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic i_req_s;
  logic d_req_s;
  logic grant_i_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 means the data cache was granted most recently.
  logic last_d_r;

  // Tie goes to whoever was not served last.
  always_comb begin
    grant_i_s = i_req_s & (~d_req_s | last_d_r);
  end

  // Last-grant register: updates on every grant taken from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_r <= 1'b1;
    end else if ((state_r == IDLE) && (i_req_s || d_req_s)) begin
      last_d_r <= ~grant_i_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`else
  // Fixed priority: I is granted only when D is not asking.
  always_comb begin
    grant_i_s = i_req_s & ~d_req_s;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. Every transaction returns to IDLE for one cycle, which
  // lets the just-served requester drop its request before re-arbitration.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          next_state_s = I_BUSY;
        end else if (d_req_s) begin
          next_state_s = D_BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = I_BUSY;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = D_BUSY;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Memory-side strobes/address and requester responses for the owner.
  // A stray pmem_resp in IDLE is never forwarded.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = {ADDR_W{1'b0}};
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_r)
      IDLE: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      I_BUSY: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        i_resp    = pmem_resp;
      end
      D_BUSY: begin
        // A writeback takes precedence if both strobes are raised.
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        pmem_addr  = d_addr;
        d_resp     = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  // Data paths are shared; each line is meaningful only while its resp is high.
  assign pmem_wdata = d_wdata;
  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;

  int n_total = 0;
  int n_pass  = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = {LW{1'b0}}; pmem_rdata = {LW{1'b0}};
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    pmem_resp = 1'b1; #1;
    n_total++; if (pmem_read !== 1'b0) $display("FAIL reset pmem_read=%b exp=0", pmem_read); else n_pass++;
    n_total++; if (pmem_write !== 1'b0) $display("FAIL reset pmem_write=%b exp=0", pmem_write); else n_pass++;
    n_total++; if (pmem_addr !== 32'h0) $display("FAIL reset pmem_addr=%h exp=0", pmem_addr); else n_pass++;
    n_total++; if (i_resp !== 1'b0) $display("FAIL reset i_resp=%b exp=0", i_resp); else n_pass++;
    n_total++; if (d_resp !== 1'b0) $display("FAIL reset d_resp=%b exp=0", d_resp); else n_pass++;
    @(negedge clk); rst = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic test_single_i_read();
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    @(negedge clk); i_read = 1'b1; i_addr = 32'h0000_0060; #1;
    n_total++; if (pmem_read !== 1'b0) $display("FAIL single_rd grant_early pmem_read=%b exp=0", pmem_read); else n_pass++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      pmem_resp  = (c == 4);
      pmem_rdata = (c == 4) ? line : {LW{1'b0}};
      if (c == 5) i_read = 1'b0;
      #1;
      n_total++; if (pmem_read !== (c <= 4)) $display("FAIL single_rd cyc%0d pmem_read=%b exp=%b", c, pmem_read, (c <= 4)); else n_pass++;
      n_total++; if (i_resp !== (c == 4)) $display("FAIL single_rd cyc%0d i_resp=%b exp=%b", c, i_resp, (c == 4)); else n_pass++;
      n_total++; if (d_resp !== 1'b0) $display("FAIL single_rd cyc%0d d_resp=%b exp=0", c, d_resp); else n_pass++;
      if (c <= 4) begin
        n_total++; if (pmem_addr !== 32'h60) $display("FAIL single_rd cyc%0d pmem_addr=%h exp=60", c, pmem_addr); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if (i_rdata !== line) $display("FAIL single_rd i_rdata=%h exp=%h", i_rdata, line); else n_pass++;
      end
    end
  endtask

  task automatic test_d_writeback();
    logic [LW-1:0] wl;
    wl = {8{32'h1234_5678}};
    @(negedge clk); d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = wl; #1;
    n_total++; if (pmem_wdata !== wl) $display("FAIL d_wb pmem_wdata=%h exp=%h", pmem_wdata, wl); else n_pass++;
    @(negedge clk); pmem_resp = 1'b1; #1;
    n_total++; if (pmem_write !== 1'b1) $display("FAIL d_wb pmem_write=%b exp=1", pmem_write); else n_pass++;
    n_total++; if (pmem_read !== 1'b0) $display("FAIL d_wb pmem_read=%b exp=0", pmem_read); else n_pass++;
    n_total++; if (pmem_addr !== 32'h1000) $display("FAIL d_wb pmem_addr=%h exp=1000", pmem_addr); else n_pass++;
    n_total++; if (d_resp !== 1'b1) $display("FAIL d_wb d_resp=%b exp=1", d_resp); else n_pass++;
    n_total++; if (i_resp !== 1'b0) $display("FAIL d_wb i_resp=%b exp=0", i_resp); else n_pass++;
    @(negedge clk); pmem_resp = 1'b0; d_write = 1'b0; #1;
    n_total++; if (pmem_write !== 1'b0) $display("FAIL d_wb after pmem_write=%b exp=0", pmem_write); else n_pass++;
  endtask

  // Three simultaneous I/D pairs; each pair checks who is served first.
  task automatic test_tie();
    bit first_i;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      first_i = RR;  // round robin: I then D each pair; fixed: D then I
      @(negedge clk);
      i_read = 1'b1; i_addr = 32'h0000_2000 + 32'(p) * 32'h20;
      d_read = 1'b1; d_addr = 32'h0000_8000 + 32'(p) * 32'h20;
      for (int s = 0; s < 2; s++) begin
        bit serve_i;
        serve_i = (s == 0) ? first_i : ~first_i;
        @(negedge clk); pmem_resp = 1'b1; #1;
        n_total++; if (pmem_read !== 1'b1) $display("FAIL tie p%0d s%0d pmem_read=%b exp=1", p, s, pmem_read); else n_pass++;
        n_total++; if (pmem_addr !== (serve_i ? i_addr : d_addr)) $display("FAIL tie p%0d s%0d pmem_addr=%h exp=%h", p, s, pmem_addr, serve_i ? i_addr : d_addr); else n_pass++;
        n_total++; if (i_resp !== serve_i) $display("FAIL tie p%0d s%0d i_resp=%b exp=%b", p, s, i_resp, serve_i); else n_pass++;
        n_total++; if (d_resp !== !serve_i) $display("FAIL tie p%0d s%0d d_resp=%b exp=%b", p, s, d_resp, !serve_i); else n_pass++;
        @(negedge clk); pmem_resp = 1'b0;
        if (serve_i) i_read = 1'b0; else d_read = 1'b0;
        #1;
        n_total++; if (pmem_read !== 1'b0) $display("FAIL tie p%0d s%0d gap pmem_read=%b exp=0", p, s, pmem_read); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); d_read = 1'b1; d_addr = 32'h0000_4040;
    @(negedge clk); rst = 1'b1; #1;
    n_total++; if (pmem_read !== 1'b1) $display("FAIL rst_mid busy pmem_read=%b exp=1", pmem_read); else n_pass++;
    @(negedge clk); rst = 1'b0; d_read = 1'b0; pmem_resp = 1'b1;
    i_read = 1'b1; i_addr = 32'h0000_0a00; #1;
    n_total++; if (pmem_read !== 1'b0) $display("FAIL rst_mid pmem_read=%b exp=0", pmem_read); else n_pass++;
    n_total++; if (pmem_write !== 1'b0) $display("FAIL rst_mid pmem_write=%b exp=0", pmem_write); else n_pass++;
    n_total++; if (d_resp !== 1'b0) $display("FAIL rst_mid d_resp=%b exp=0", d_resp); else n_pass++;
    @(negedge clk); pmem_resp = 1'b1; #1;
    n_total++; if (pmem_read !== 1'b1) $display("FAIL rst_mid regrant pmem_read=%b exp=1", pmem_read); else n_pass++;
    n_total++; if (pmem_addr !== 32'h0a00) $display("FAIL rst_mid regrant pmem_addr=%h exp=a00", pmem_addr); else n_pass++;
    n_total++; if (i_resp !== 1'b1) $display("FAIL rst_mid regrant i_resp=%b exp=1", i_resp); else n_pass++;
    @(negedge clk); pmem_resp = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_stray_resp();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs(); pmem_resp = 1'b1; #1;
      n_total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) $display("FAIL stray cyc%0d i_resp=%b d_resp=%b exp=0,0", c, i_resp, d_resp); else n_pass++;
      n_total++; if (pmem_read !== 1'b0 || pmem_addr !== 32'h0) $display("FAIL stray cyc%0d pmem_read=%b pmem_addr=%h exp=0,0", c, pmem_read, pmem_addr); else n_pass++;
    end
    // Still idle: a fresh request is granted one cycle later.
    @(negedge clk); pmem_resp = 1'b0; d_read = 1'b1; d_addr = 32'h0000_0100;
    @(negedge clk); pmem_resp = 1'b1; #1;
    n_total++; if (pmem_read !== 1'b1 || d_resp !== 1'b1) $display("FAIL stray regrant pmem_read=%b d_resp=%b exp=1,1", pmem_read, d_resp); else n_pass++;
    @(negedge clk); idle_inputs();
  endtask

  // Random traffic against a transaction-level model: who owns the port,
  // which request waits, and which line each requester must observe.
  task automatic test_random();
    bit i_pend = 1'b0, d_pend = 1'b0, d_rd = 1'b0, d_wr = 1'b0, pr;
    bit last_d = 1'b1;
    int owner = 0, cnt = 0, lat = 0, win;
    logic [AW-1:0] ia = 32'h0, da = 32'h0;
    logic [LW-1:0] dw = {LW{1'b0}}, rd;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rd = rand_line();
      pr = (owner != 0) ? (cnt == lat) : ($urandom_range(0, 7) == 0);
      i_read = i_pend; i_addr = ia;
      d_read = d_pend & d_rd; d_write = d_pend & d_wr; d_addr = da; d_wdata = dw;
      pmem_resp = pr; pmem_rdata = rd;
      #1;
      e_rd   = (owner == 1) || (owner == 2 && d_read && !d_write);
      e_wr   = (owner == 2) && d_write;
      e_addr = (owner == 1) ? ia : (owner == 2) ? da : 32'h0;
      n_total++; if (pmem_read !== e_rd) $display("FAIL rand cyc%0d pmem_read=%b exp=%b", cyc, pmem_read, e_rd); else n_pass++;
      n_total++; if (pmem_write !== e_wr) $display("FAIL rand cyc%0d pmem_write=%b exp=%b", cyc, pmem_write, e_wr); else n_pass++;
      n_total++; if (pmem_addr !== e_addr) $display("FAIL rand cyc%0d pmem_addr=%h exp=%h", cyc, pmem_addr, e_addr); else n_pass++;
      n_total++; if (i_resp !== (owner == 1 && pr)) $display("FAIL rand cyc%0d i_resp=%b exp=%b", cyc, i_resp, (owner == 1 && pr)); else n_pass++;
      n_total++; if (d_resp !== (owner == 2 && pr)) $display("FAIL rand cyc%0d d_resp=%b exp=%b", cyc, d_resp, (owner == 2 && pr)); else n_pass++;
      n_total++; if (i_rdata !== rd || d_rdata !== rd) $display("FAIL rand cyc%0d rdata i=%h d=%h exp=%h", cyc, i_rdata, d_rdata, rd); else n_pass++;
      n_total++; if (pmem_wdata !== dw) $display("FAIL rand cyc%0d pmem_wdata=%h exp=%h", cyc, pmem_wdata, dw); else n_pass++;
      // Port ownership for the next cycle.
      if (owner != 0) begin
        if (pr) begin
          if (owner == 1) i_pend = 1'b0; else d_pend = 1'b0;
          owner = -owner;  // marks the completed requester for this update only
        end else begin
          cnt++;
        end
      end else if (i_pend || d_pend) begin
        if (i_pend && d_pend) win = (RR && last_d) ? 1 : 2;
        else win = i_pend ? 1 : 2;
        owner = win; cnt = 0; lat = $urandom_range(0, 3); last_d = (win == 2);
      end
      // New requests; a requester just completed stays low for one cycle.
      if (owner != -1 && !i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; ia = $urandom & 32'hFFFF_FFE0;
      end
      if (owner != -2 && !d_pend && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        d_pend = 1'b1; da = $urandom & 32'hFFFF_FFE0; dw = rand_line();
        d_rd = (k <= 4) || (k == 9); d_wr = (k >= 5);
      end
      if (owner < 0) owner = 0;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_tie();
    test_reset_mid();
    test_stray_resp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
